// File: rtl/clk_period_monitor.sv
// Measures one falling-to-falling period and its high phase of an asynchronous mon_clk, in mclk cycles.
// Limitation: a mon_clk stuck high or low while armed never produces an edge, so ARM waits until reset.
module clk_period_monitor #(
    parameter int CNT_W = 16,
    parameter int TOL   = 1
) (
    input  logic             mclk,
    input  logic             rst,
    input  logic             mon_clk,
    input  logic             start,
    input  logic [CNT_W-1:0] exp_period,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             period_ok,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [CNT_W-1:0] SAT      = ALL_ONES - 1'b1;
    localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);

    state_t           state_reg, state_next;
    logic [2:0]       sync_reg;
    logic [CNT_W-1:0] period_cnt_reg;
    logic [CNT_W-1:0] high_cnt_reg;
    logic [CNT_W-1:0] exp_reg;
    logic             mon_level;
    logic             mon_fall;
    logic             sat_hit;
    logic [CNT_W:0]   diff;

    // Bits [1:0] are the synchroniser, bit [2] is the edge-detect history.
    assign mon_level = sync_reg[1];
    assign mon_fall  = sync_reg[2] & ~sync_reg[1];
    assign sat_hit   = (period_cnt_reg == SAT);

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sync_reg  <= '0;
            state_reg <= IDLE;
        end else begin
            sync_reg  <= {sync_reg[1:0], mon_clk};
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = ARM;
            end
            ARM: begin
                busy = 1'b1;
                if (mon_fall) state_next = MEAS;
            end
            MEAS: begin
                busy = 1'b1;
                if (mon_fall || sat_hit) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Widened by one bit so the absolute difference never wraps.
    always_comb begin
        if ({1'b0, meas_period} >= {1'b0, exp_reg})
            diff = {1'b0, meas_period} - {1'b0, exp_reg};
        else
            diff = {1'b0, exp_reg} - {1'b0, meas_period};
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            period_cnt_reg <= '0;
            high_cnt_reg   <= '0;
            exp_reg        <= '0;
            meas_period    <= '0;
            meas_high      <= '0;
            period_ok      <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        exp_reg   <= exp_period;
                        period_ok <= 1'b0;
                        timeout   <= 1'b0;
                    end
                end
                ARM: begin
                    if (mon_fall) begin
                        period_cnt_reg <= '0;
                        high_cnt_reg   <= '0;
                    end
                end
                MEAS: begin
                    if (mon_fall) begin
                        meas_period <= period_cnt_reg + 1'b1;
                        meas_high   <= high_cnt_reg;
                    end else if (sat_hit) begin
                        timeout     <= 1'b1;
                        meas_period <= ALL_ONES;
                        period_ok   <= 1'b0;
                    end else begin
                        period_cnt_reg <= period_cnt_reg + 1'b1;
                        if (mon_level) high_cnt_reg <= high_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    period_ok <= ~timeout && (diff <= TOL_W);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: expectations are queued at start and checked after each done pulse.
module tb_clk_period_monitor;

    localparam int W = 8;

    logic         mclk = 1'b0;
    logic         rst;
    logic         mon_clk;
    logic         start;
    logic [W-1:0] exp_period;
    logic         busy;
    logic         done;
    logic [W-1:0] meas_period;
    logic [W-1:0] meas_high;
    logic         period_ok;
    logic         timeout;

    clk_period_monitor #(.CNT_W(W), .TOL(1)) dut (
        .mclk        (mclk),
        .rst         (rst),
        .mon_clk     (mon_clk),
        .start       (start),
        .exp_period  (exp_period),
        .busy        (busy),
        .done        (done),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .period_ok   (period_ok),
        .timeout     (timeout)
    );

    always #5 mclk = ~mclk;

    // Monitored clock: low for (per-high) mclk cycles, then high for 'high' cycles.
    int   mon_per  = 20;
    int   mon_high = 10;
    int   phase    = 0;
    bit   mon_en   = 1'b1;
    logic gen_clk  = 1'b0;
    logic man_clk  = 1'b0;

    always @(negedge mclk) begin
        if (phase >= mon_per - 1) phase = 0;
        else phase = phase + 1;
        gen_clk = (phase >= mon_per - mon_high);
    end

    assign mon_clk = mon_en ? gen_clk : man_clk;

    typedef struct {
        logic [W-1:0] period;
        logic [W-1:0] high;
        logic         ok;
        logic         to;
        logic         chk_high;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic pulse_start(input logic [W-1:0] e);
        @(negedge mclk);
        exp_period = e;
        start      = 1'b1;
        @(negedge mclk);
        start      = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cycles, output bit found);
        cycles = 0;
        found  = 1'b0;
        while (cycles < bound && !found) begin
            @(negedge mclk);
            cycles++;
            if (done === 1'b1) found = 1'b1;
        end
    endtask

    task automatic finish_check(input string tag, input bit found);
        exp_t e;
        chk({tag, "_done_seen"}, found, 1);
        if (found && sb.size() > 0) begin
            @(negedge mclk);
            e = sb.pop_front();
            chk({tag, "_period"}, meas_period, e.period);
            if (e.chk_high) chk({tag, "_high"}, meas_high, e.high);
            chk({tag, "_ok"}, period_ok, e.ok);
            chk({tag, "_timeout"}, timeout, e.to);
            chk({tag, "_done_1cyc"}, done, 0);
            chk({tag, "_busy_after"}, busy, 0);
        end else begin
            sb.delete();
        end
    endtask

    task automatic measure(input string tag, input logic [W-1:0] e, input logic [W-1:0] p,
                           input logic [W-1:0] h, input logic ok);
        exp_t x;
        int   cycles;
        bit   found;
        x.period = p; x.high = h; x.ok = ok; x.to = 1'b0; x.chk_high = 1'b1;
        sb.push_back(x);
        pulse_start(e);
        chk({tag, "_busy"}, busy, 1);
        wait_done(200, cycles, found);
        finish_check(tag, found);
    endtask

    task automatic wait_gen_rise();
        int n = 0;
        @(negedge mclk); #1;
        while (gen_clk !== 1'b0 && n < 60) begin @(negedge mclk); #1; n++; end
        while (gen_clk !== 1'b1 && n < 60) begin @(negedge mclk); #1; n++; end
    endtask

    initial begin
        int   cycles;
        int   extra;
        bit   found;
        exp_t x;

        rst = 1'b1; start = 1'b0; exp_period = '0;
        cyc(3);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_period", meas_period, 0);
        chk("rst_high", meas_high, 0);
        chk("rst_ok", period_ok, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        cyc(5);

        measure("p20_exp20", 8'd20, 8'd20, 8'd10, 1'b1);
        measure("p20_exp23", 8'd23, 8'd20, 8'd10, 1'b0);
        measure("p20_exp21", 8'd21, 8'd20, 8'd10, 1'b1);
        measure("p20_exp19", 8'd19, 8'd20, 8'd10, 1'b1);
        measure("p20_exp18", 8'd18, 8'd20, 8'd10, 1'b0);

        mon_per = 16; mon_high = 4;
        cyc(40);
        measure("p16_duty25", 8'd16, 8'd16, 8'd4, 1'b1);

        // Start pulses with a bad exp_period while busy must not disturb the measurement.
        mon_per = 20; mon_high = 10;
        cyc(45);
        x.period = 8'd20; x.high = 8'd10; x.ok = 1'b1; x.to = 1'b0; x.chk_high = 1'b1;
        sb.push_back(x);
        pulse_start(8'd20);
        for (int k = 0; k < 3; k++) begin
            cyc(3);
            if (busy) begin
                exp_period = 8'd5;
                start      = 1'b1;
                @(negedge mclk);
                start      = 1'b0;
            end
        end
        wait_done(200, cycles, found);
        finish_check("restart_ignored", found);
        extra = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge mclk);
            if (done) extra++;
        end
        chk("restart_single_done", extra, 0);

        // One falling edge, then mon_clk held high until the counter saturates.
        mon_en = 1'b0; man_clk = 1'b1;
        cyc(5);
        x.period = 8'd255; x.high = '0; x.ok = 1'b0; x.to = 1'b1; x.chk_high = 1'b0;
        sb.push_back(x);
        pulse_start(8'd255);
        cyc(4);
        man_clk = 1'b0;
        cyc(3);
        man_clk = 1'b1;
        wait_done(400, cycles, found);
        chk("timeout_latency_in_range", (cycles + 3 >= 250) && (cycles + 3 <= 262), 1);
        finish_check("timeout", found);

        // Reset in the middle of a measurement aborts it without a done pulse.
        mon_en = 1'b1;
        cyc(45);
        wait_gen_rise();
        exp_period = 8'd20;
        start      = 1'b1;
        @(negedge mclk);
        start      = 1'b0;
        cyc(20);
        chk("abort_busy_before", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_period", meas_period, 0);
        chk("abort_high", meas_high, 0);
        chk("abort_ok", period_ok, 0);
        chk("abort_timeout", timeout, 0);
        cyc(2);
        rst = 1'b0;
        extra = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge mclk);
            if (done || busy) extra++;
        end
        chk("abort_stays_idle", extra, 0);
        measure("after_abort", 8'd20, 8'd20, 8'd10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
